hasti_sram: RTL

HASTI (AHB-Lite) slave SRAM that sits directly downstream of the bus decoder/mux on the s1 (RAM) port. It consumes the decoded slave-side signals and returns hrdata, hreadyout and hresp to the bus mux. Supports byte, halfword and word accesses, a programmable number of wait states, and a two-cycle ERROR response for illegal transfers.

---
 rtl/hasti_sram.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/hasti_sram.sv
// rtl/hasti_sram.sv - AHB-Lite (HASTI) SRAM slave with wait states and two-cycle ERROR
// Optional HASTI_SRAM_ERR_EN: addresses beyond the array give ERROR instead of wrapping.
module hasti_sram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lsb_q, lsb_d;
  logic [1:0]    size_q, size_d;
  logic          pend_q, pend_d;
  logic [31:0]   hrdata_q, hrdata_d;
  logic          hreadyout_q, hreadyout_d;
  logic          hresp_q, hresp_d;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] a_idx;
  logic          decode, accept, illegal, commit, fwd;
  logic [3:0]    be;
  logic [31:0]   rd_word;
  logic          unused_ok;

  assign a_idx     = haddr[AW+1:2];
  assign commit    = pend_q && (state_q == S_IDLE);
  assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0], haddr[31:AW+2]};

  always_comb begin
    illegal = (hsize > 3'd2) || (hsize == 3'd1 && haddr[0]) ||
              (hsize == 3'd2 && haddr[1:0] != 2'b00);
`ifdef HASTI_SRAM_ERR_EN
    if (|haddr[31:AW+2]) illegal = 1'b1;
`endif
  end

  always_comb begin
    case (size_q)
      2'd0:    be = 4'b0001 << lsb_q;
      2'd1:    be = 4'b0011 << lsb_q;
      default: be = 4'b1111;
    endcase
  end

  // A read accepted on the edge that commits a write to the same word sees the new lanes.
  always_comb begin
    rd_word = mem[a_idx];
    fwd     = commit && (idx_q == a_idx);
    for (int i = 0; i < 4; i++) begin
      if (fwd && be[i]) rd_word[8*i +: 8] = hwdata[8*i +: 8];
    end
  end

  always_ff @(posedge hclk) begin
    for (int i = 0; i < 4; i++) begin
      if (commit && be[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lsb_d    = lsb_q;
    size_d   = size_q;
    pend_d   = pend_q;
    hrdata_d = hrdata_q;
    decode   = (state_q == S_IDLE) || (state_q == S_ERR2);
    accept   = decode && hsel && hready && htrans[1];
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_IDLE;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
        if (accept) begin
          idx_d  = a_idx;
          lsb_d  = haddr[1:0];
          size_d = hsize[1:0];
          if (illegal) begin
            state_d = S_ERR1;
          end else begin
            pend_d = hwrite;
            if (!hwrite) hrdata_d = rd_word;
            if (WS != 3'd0) begin
              state_d = S_WAIT;
              cnt_d   = WS;
            end
          end
        end
      end
    endcase
    hreadyout_d = !(state_d == S_WAIT || state_d == S_ERR1);
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      lsb_q       <= '0;
      size_q      <= '0;
      pend_q      <= 1'b0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lsb_q       <= lsb_d;
      size_q      <= size_d;
      pend_q      <= pend_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign hrdata    = hrdata_q;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
endmodule
